// File: rtl/vga_pkg.sv
// Shared VGA timing constants, control-bundle type and width helper.
package vga_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock (default set)
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 320x240-class reduced raster for small or simulation builds
  localparam int VGA320_H_ACTIVE = 320;
  localparam int VGA320_H_FP     = 8;
  localparam int VGA320_H_SYNC   = 48;
  localparam int VGA320_H_BP     = 24;
  localparam int VGA320_V_ACTIVE = 240;
  localparam int VGA320_V_FP     = 5;
  localparam int VGA320_V_SYNC   = 1;
  localparam int VGA320_V_BP     = 17;

  // Raster control bits that travel together through the delay line.
  // hs/vs are carried active-high here; polarity is applied at the output.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } vga_ctrl_t;

  localparam int VGA_CTRL_W = $bits(vga_ctrl_t);

  // Counter width needed to hold 0..n-1 (never less than one bit).
  function automatic int width_for(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle from the timing generator to the effect logic.
interface vga_timing_gen_if #(
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int FRAME_W = 8
);
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [FRAME_W-1:0] frame;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic               line_start;
  logic               frame_start;

  modport master (
    output x, y, frame, hsync, vsync, de, line_start, frame_start
  );

  modport slave (
    input x, y, frame, hsync, vsync, de, line_start, frame_start
  );
endinterface

// File: rtl/sync_delay.sv
// DEPTH x WIDTH shift register advancing on ce, with synchronous clear.
// Also used by effect blocks to align colour data with the sync outputs.
module sync_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one stage per ce; the whole chain is cleared on reset.
  // NOTE: these are individual flops, not a RAM, so clearing every entry is
  // cheap and keeps stale raster bits from leaking out after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (ce) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: walks H/V counters on ce, emits x/y/frame and
// PIPE-delayed sync, data-enable and line/frame strobes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE     = 2,
  parameter int FRAME_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = width_for(H_TOTAL);
  localparam int YW      = width_for(V_TOTAL);

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [XW-1:0] h;
  logic [YW-1:0] v;
  logic          primed;   // set after the first ce; blocks a frame bump at (0,0) after reset
  vga_ctrl_t     raw_d;
  vga_ctrl_t     raw_q;
  vga_ctrl_t     dly;

  // Raster counters: h walks the line, v advances on each line wrap.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (ce) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + YW'(1);
      end else begin
        h <= h + XW'(1);
      end
    end
  end

  // Raw decodes of the current counter position.
  // NOTE: the default assignment first means no path leaves a field unassigned,
  // so no latch is inferred.
  always_comb begin
    raw_d    = '0;
    raw_d.de = (h < H_ACT) && (v < V_ACT);
    raw_d.hs = (h >= HS_START) && (h < HS_END);
    raw_d.vs = (v >= VS_START) && (v < VS_END);
    raw_d.ls = (h == '0);
    raw_d.fs = (h == '0) && (v == '0);
  end

  // Stage 0: register coordinates, frame count and raw decodes together.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga.x     <= '0;
      vga.y     <= '0;
      vga.frame <= '0;
      raw_q     <= '0;
      primed    <= 1'b0;
    end else if (ce) begin
      vga.x  <= h;
      vga.y  <= v;
      raw_q  <= raw_d;
      primed <= 1'b1;
      if (primed && (h == '0) && (v == '0)) vga.frame <= vga.frame + FRAME_W'(1);
    end
  end

  // Align control bits with the downstream colour pipeline.
  if (PIPE == 0) begin : g_no_pipe
    assign dly = raw_q;
  end else begin : g_pipe
    logic [VGA_CTRL_W-1:0] dly_bits;
    sync_delay #(
      .DEPTH (PIPE),
      .WIDTH (VGA_CTRL_W)
    ) u_delay (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .d   (raw_q),
      .q   (dly_bits)
    );
    assign dly = vga_ctrl_t'(dly_bits);
  end

  // Apply sync polarity; a cleared delay line yields the deasserted level.
  assign vga.hsync       = dly.hs ~^ HS_POL;
  assign vga.vsync       = dly.vs ~^ VS_POL;
  assign vga.de          = dly.de;
  assign vga.line_start  = dly.ls;
  assign vga.frame_start = dly.fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 16x8 raster, PIPE=2 and PIPE=0.
module tb_vga_timing_gen;

  localparam int XW = 4;
  localparam int YW = 3;
  localparam int FW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;

  int total = 0;
  int bad   = 0;
  int n     = 0;   // ce count since reset release

  always #5 clk = ~clk;

  vga_timing_gen_if #(.XW(XW), .YW(YW), .FRAME_W(FW)) v2 ();
  vga_timing_gen_if #(.XW(XW), .YW(YW), .FRAME_W(FW)) v0 ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(2), .FRAME_W(FW)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .vga (v2.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(0), .FRAME_W(FW)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .vga (v0.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  // Expected {de, hsync, vsync, line_start, frame_start} for pixel index p
  // of the raster stream; negative p means the delay line is still idle.
  function automatic logic [4:0] flags(input int p);
    int hx;
    int vy;
    if (p < 0) return 5'b01100;
    hx = p % 16;
    vy = (p / 16) % 8;
    return {(hx < 8) && (vy < 4), !((hx >= 10) && (hx < 13)), vy != 5,
            hx == 0, (p % 128) == 0};
  endfunction

  function automatic int exp_x();
    return (n == 0) ? 0 : (n - 1) % 16;
  endfunction

  function automatic int exp_y();
    return (n == 0) ? 0 : ((n - 1) / 16) % 8;
  endfunction

  task automatic check_all(input string ph);
    logic [4:0] f2;
    logic [4:0] f0;
    int fr;
    f2 = flags(n - 3);
    f0 = flags(n - 1);
    fr = (n == 0) ? 0 : ((n - 1) / 128) % 16;
    check({ph, ".x"},      32'(v2.x),           32'(exp_x()));
    check({ph, ".y"},      32'(v2.y),           32'(exp_y()));
    check({ph, ".frame"},  32'(v2.frame),       32'(fr));
    check({ph, ".de"},     32'(v2.de),          32'(f2[4]));
    check({ph, ".hsync"},  32'(v2.hsync),       32'(f2[3]));
    check({ph, ".vsync"},  32'(v2.vsync),       32'(f2[2]));
    check({ph, ".ls"},     32'(v2.line_start),  32'(f2[1]));
    check({ph, ".fs"},     32'(v2.frame_start), 32'(f2[0]));
    check({ph, ".p0.x"},   32'(v0.x),           32'(exp_x()));
    check({ph, ".p0.de"},  32'(v0.de),          32'(f0[4]));
    check({ph, ".p0.hs"},  32'(v0.hsync),       32'(f0[3]));
    check({ph, ".p0.vs"},  32'(v0.vsync),       32'(f0[2]));
    check({ph, ".p0.fs"},  32'(v0.frame_start), 32'(f0[0]));
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input bit ce_v, input bit rst_v);
    @(negedge clk);
    ce  = ce_v;
    rst = rst_v;
    @(posedge clk);
    #1;
    if (rst_v) n = 0;
    else if (ce_v) n++;
  endtask

  initial begin
    int vs_low;
    int run;
    int last_run;
    int fs_cnt;
    int guard;

    // Reset with ce high: everything idle, syncs deasserted.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check_all("reset");

    // Reset release, full frame plus a few pixels of the next.
    vs_low = 0;
    for (int i = 0; i < 140; i++) begin
      step(1'b1, 1'b0);
      check_all("run");
      if (n >= 3 && n <= 130 && v2.vsync == 1'b0) vs_low++;
      if (n == 3) check("first_ls", 32'(v2.line_start), 32'd1);
      if (n == 13) check("hs_first_low", 32'(v2.hsync), 32'd0);
      if (n == 129) check("frame_bump", 32'(v2.frame), 32'd1);
      if (n == 131) check("fs_frame1", 32'(v2.frame_start), 32'd1);
    end
    check("vsync_low_len", 32'(vs_low), 32'd16);

    // ce every third clock: same sequence, outputs hold between enables.
    run = 0;
    last_run = 0;
    for (int i = 0; i < 3 * 40; i++) begin
      step((i % 3) == 0, 1'b0);
      check_all("ce3");
      if (v2.hsync == 1'b0) run++;
      else begin
        if (run > 0) last_run = run;
        run = 0;
      end
    end
    check("hs_width_clk", 32'(last_run), 32'd9);

    // Run to line 2, x=5, then reset for one cycle.
    guard = 0;
    while (!(exp_x() == 5 && exp_y() == 2) && guard < 300) begin
      step(1'b1, 1'b0);
      check_all("seek");
      guard++;
    end
    check("seek_x", 32'(v2.x), 32'd5);
    check("seek_y", 32'(v2.y), 32'd2);
    step(1'b1, 1'b1);
    check_all("midrst");
    check("midrst_hsync", 32'(v2.hsync), 32'd1);
    check("midrst_vsync", 32'(v2.vsync), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      check_all("resume");
    end

    // Sixteen frames: frame counter wraps to 0, one frame_start per frame.
    fs_cnt = 0;
    while (n < 16 * 128 + 1) begin
      step(1'b1, 1'b0);
      check_all("wrap");
      if (v2.frame_start) fs_cnt++;
    end
    check("wrap_frame", 32'(v2.frame), 32'd0);
    check("wrap_fs_count", 32'(fs_cnt), 32'd15);

    // ce held low: nothing moves.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      check_all("freeze");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: bench did not reach the end (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
